// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package regfile_pkg;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} rf_state_t;

  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;

  // Callers zero-extend their AW-bit address into the 32-bit argument.
  function automatic logic is_zero_addr(input logic [31:0] addr);
    return (addr == 32'd0);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by reserve, cleared by write or by the clear engine.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG  = RF_NREG,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wclr_en,
  input  logic [AW-1:0]       wclr_addr,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                eclr_en,
  input  logic [AW-1:0]       eclr_addr,
  input  logic [NREAD*AW-1:0] ra,
  output logic [NREAD-1:0]    busy_lk
);

  logic [NREG-1:0] busy_r;

  // Busy state update; reserve is applied after write-clear so it wins on a tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= {NREG{1'b0}};
    end else if (eclr_en) begin
      busy_r[eclr_addr] <= 1'b0;
    end else begin
      if (wclr_en) busy_r[wclr_addr] <= 1'b0;
      if (rsv_en)  busy_r[rsv_addr]  <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_lookup
    assign busy_lk[gi] = busy_r[ra[gi*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional write bypass, busy scoreboard
// and a one-register-per-cycle clear engine; register 0 reads as zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREG   = RF_NREG,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd,
  output logic [NREAD-1:0]      busy_rd,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  input  logic                  clr_req,
  output logic                  clr_busy
);

  logic [XLEN-1:0] regs_r [NREG];
  rf_state_t       state_r;
  logic [AW-1:0]   cnt_r;
  logic            clr_busy_r;
  logic [NREAD-1:0] sb_busy_s;
  logic            idle_s, wr_en_s, rsv_ok_s, byp_s, rsv_same_s;

  // Writes and reserves only land in IDLE and are dropped on the clear-start cycle.
  assign idle_s     = (state_r == IDLE);
  assign wr_en_s    = idle_s && !clr_req && we && !is_zero_addr(32'(wa));
  assign rsv_ok_s   = idle_s && !clr_req && rsv_en && !is_zero_addr(32'(rsv_addr));
  assign byp_s      = (BYPASS != 0) && idle_s && we && !is_zero_addr(32'(wa));
  assign rsv_same_s = rsv_en && (rsv_addr == wa);
  assign clr_busy   = clr_busy_r;

  rf_scoreboard #(.NREG(NREG), .NREAD(NREAD), .AW(AW)) u_sb (
    .clock     (clock),
    .reset_n   (reset_n),
    .wclr_en   (wr_en_s),
    .wclr_addr (wa),
    .rsv_en    (rsv_ok_s),
    .rsv_addr  (rsv_addr),
    .eclr_en   (!idle_s),
    .eclr_addr (cnt_r),
    .ra        (ra),
    .busy_lk   (sb_busy_s)
  );

  // Data array, clear counter and clear FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREG; k++) regs_r[k] <= {XLEN{1'b0}};
      state_r    <= IDLE;
      cnt_r      <= {AW{1'b0}};
      clr_busy_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (clr_req) begin
            state_r    <= CLEAR;
            cnt_r      <= AW'(1'b1);
            clr_busy_r <= 1'b1;
          end else if (wr_en_s) begin
            regs_r[wa] <= wd;
          end
        end
        CLEAR: begin
          regs_r[cnt_r] <= {XLEN{1'b0}};
          if (cnt_r == AW'(NREG - 1)) begin
            state_r    <= IDLE;
            cnt_r      <= {AW{1'b0}};
            clr_busy_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + AW'(1'b1);
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= {AW{1'b0}};
          clr_busy_r <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
    logic [AW-1:0]   addr_s;
    logic [XLEN-1:0] data_s;
    logic            busy_s;

    assign addr_s = ra[gi*AW +: AW];

    // Read mux: zero register, then same-cycle bypass, then stored state.
    always_comb begin
      data_s = {XLEN{1'b0}};
      busy_s = 1'b0;
      if (is_zero_addr(32'(addr_s))) begin
        data_s = {XLEN{1'b0}};
        busy_s = 1'b0;
      end else if (byp_s && (wa == addr_s)) begin
        data_s = wd;
        busy_s = rsv_same_s;
      end else begin
        data_s = regs_r[addr_s];
        busy_s = sb_busy_s[gi];
      end
    end

    assign rd[gi*XLEN +: XLEN] = data_s;
    assign busy_rd[gi]         = busy_s;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized bench for regfile_mp, run with and without bypass.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [NREAD*AW-1:0]   ra;
  logic [NREAD*XLEN-1:0] rd, rd_nb;
  logic [NREAD-1:0]      busy_rd, busy_nb;
  logic                  we, rsv_en, clr_req, clr_busy, clr_busy_nb;
  logic [AW-1:0]         wa, rsv_addr;
  logic [XLEN-1:0]       wd;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural contents, busy flags and clear progress.
  logic [31:0] m_reg [NREG];
  bit          m_busy [NREG];
  bit          m_clear;
  int          m_idx;

  always #5 clock = ~clock;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .BYPASS(1)) dut (
    .clock(clock), .reset_n(reset_n), .ra(ra), .rd(rd), .busy_rd(busy_rd),
    .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .BYPASS(0)) dut_nb (
    .clock(clock), .reset_n(reset_n), .ra(ra), .rd(rd_nb), .busy_rd(busy_nb),
    .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(clr_busy_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
    m_clear = 1'b0;
    m_idx   = 0;
  endtask

  function automatic logic [31:0] exp_rd(input int p, input bit byp);
    int a;
    a = int'(ra[p*AW +: AW]);
    if (a == 0) return 32'd0;
    if (byp && !m_clear && we && int'(wa) == a) return wd;
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(input int p, input bit byp);
    int a;
    a = int'(ra[p*AW +: AW]);
    if (a == 0) return 1'b0;
    if (byp && !m_clear && we && int'(wa) == a) return rsv_en && (rsv_addr == wa);
    return m_busy[a];
  endfunction

  task automatic check_reads();
    for (int p = 0; p < NREAD; p++) begin
      chk($sformatf("rd%0d", p), rd[p*XLEN +: XLEN], exp_rd(p, 1'b1));
      chk($sformatf("busy%0d", p), {31'd0, busy_rd[p]}, {31'd0, exp_busy(p, 1'b1)});
      chk($sformatf("rd_nb%0d", p), rd_nb[p*XLEN +: XLEN], exp_rd(p, 1'b0));
      chk($sformatf("busy_nb%0d", p), {31'd0, busy_nb[p]}, {31'd0, exp_busy(p, 1'b0)});
    end
    chk("clr_busy", {31'd0, clr_busy}, {31'd0, m_clear});
    chk("clr_busy_nb", {31'd0, clr_busy_nb}, {31'd0, m_clear});
  endtask

  // Apply the spec's edge rules to the model using the inputs held over the edge.
  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else if (m_clear) begin
      m_reg[m_idx]  = 32'd0;
      m_busy[m_idx] = 1'b0;
      if (m_idx == NREG - 1) m_clear = 1'b0;
      else m_idx++;
    end else if (clr_req) begin
      m_clear = 1'b1;
      m_idx   = 1;
    end else begin
      if (we && wa != 5'd0) begin
        m_reg[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    check_reads();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  initial begin
    int n;
    model_reset();
    we = 1'b0; wa = '0; wd = '0; rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0; ra = '0;

    // Reset then read
    #12;
    chk("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    reset_n = 1'b1;
    set_ra(5'd5, 5'd31);
    #1;
    chk("rst_rd0", rd[31:0], 32'd0);
    chk("rst_rd1", rd[63:32], 32'd0);
    chk("rst_busy", {30'd0, busy_rd}, 32'd0);
    tick();

    // Write/read and register 0
    we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF;
    tick();
    we = 1'b0; set_ra(5'd3, 5'd0); #1;
    chk("wr_rd3", rd[31:0], 32'hDEADBEEF);
    we = 1'b1; wa = 5'd0; wd = 32'h1234;
    tick();
    we = 1'b0; #1;
    chk("x0_rd", rd[63:32], 32'd0);

    // Bypass versus stored-value read
    we = 1'b1; wa = 5'd7; wd = 32'h11;
    tick();
    wd = 32'hA5A5A5A5; set_ra(5'd7, 5'd0); #1;
    chk("byp_rd", rd[31:0], 32'hA5A5A5A5);
    chk("nobyp_pre", rd_nb[31:0], 32'h11);
    tick();
    we = 1'b0; #1;
    chk("nobyp_post", rd_nb[31:0], 32'hA5A5A5A5);

    // Scoreboard
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    rsv_en = 1'b0; set_ra(5'd9, 5'd0); #1;
    chk("sb_set", {31'd0, busy_rd[0]}, 32'd1);
    we = 1'b1; wa = 5'd9; wd = 32'h99; #1;
    chk("sb_byp_busy", {31'd0, busy_rd[0]}, 32'd0);
    chk("sb_nb_busy", {31'd0, busy_nb[0]}, 32'd1);
    tick();
    we = 1'b0; #1;
    chk("sb_wclr", {31'd0, busy_rd[0]}, 32'd0);
    we = 1'b1; wa = 5'd9; wd = 32'h77; rsv_en = 1'b1; rsv_addr = 5'd9; #1;
    chk("sb_byp_rsv", {31'd0, busy_rd[0]}, 32'd1);
    tick();
    we = 1'b0; rsv_en = 1'b0; #1;
    chk("sb_tie_busy", {31'd0, busy_rd[0]}, 32'd1);
    chk("sb_tie_data", rd[31:0], 32'h77);

    // Clear sequence
    for (int i = 1; i < NREG; i++) begin
      we = 1'b1; wa = AW'(i); wd = 32'(i); set_ra(AW'(i), AW'(i - 1));
      tick();
    end
    we = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd4; set_ra(5'd4, 5'd31);
    tick();
    rsv_en = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 100) begin
      we = (n == 5); wa = 5'd2; wd = 32'hFF; set_ra(5'd2, 5'd4);
      tick();
      n++;
    end
    we = 1'b0;
    chk("clr_cycles", 32'(n), 32'd31);
    for (int a = 0; a < NREG; a++) begin
      set_ra(AW'(a), AW'(NREG - 1 - a)); #1;
      chk("clr_rd0", rd[31:0], 32'd0);
      chk("clr_rd1", rd[63:32], 32'd0);
      chk("clr_busy_rd", {30'd0, busy_rd}, 32'd0);
    end

    // Reset in the middle of a clear
    we = 1'b1; wa = 5'd6; wd = 32'h66;
    tick();
    we = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    set_ra(5'd6, 5'd1); #1;
    chk("mid_rst_rd6", rd[31:0], 32'd0);
    #3;
    reset_n = 1'b1;
    tick();
    we = 1'b1; wa = 5'd5; wd = 32'hCAFE;
    tick();
    we = 1'b0; set_ra(5'd5, 5'd6); #1;
    chk("post_rst_wr", rd[31:0], 32'hCAFE);
    chk("post_rst_rd6", rd[63:32], 32'd0);

    // Randomized traffic against the model
    repeat (400) begin
      ra       = NREAD*AW'($urandom);
      we       = 1'($urandom_range(0, 1));
      wa       = AW'($urandom);
      wd       = $urandom;
      rsv_en   = ($urandom_range(0, 3) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      clr_req  = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) ra[AW-1:0] = wa;
      tick();
    end
    clr_req = 1'b0; we = 1'b0; rsv_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the 2-read/1-write integer register file used by the single-cycle core.
- Adds a configurable number of read ports, optional write-to-read bypass for the pipelined datapath, and a per-register busy scoreboard for hazard detection.
- Adds a sequential clear engine that zeroes the architectural state one register per cycle without asserting reset.
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of two, >= 4. Localparam AW = $clog2(NREG).
- NREAD, 2, number of combinational read ports; 1..4.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return the stored value.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ra  in  NREAD*AW  read addresses; port i is ra[i*AW +: AW].
- rd  out  NREAD*XLEN  read data; port i is rd[i*XLEN +: XLEN].
- busy_rd  out  NREAD  scoreboard busy bit for each read address.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- rsv_en  in  1  reserve strobe: mark register rsv_addr busy (pending producer).
- rsv_addr  in  AW  register to reserve.
- clr_req  in  1  one-cycle request to start the clear sequence.
- clr_busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all registers are 0 and all busy bits are 0;
  - FSM is IDLE, clear counter is 0, clr_busy is 0;
  - rd and busy_rd read as 0 for every address.
- Reads are combinational, with zero latency.
- For each read port i:
  - ra[i] == 0: rd is 0 and busy_rd is 0.
  - BYPASS=1, state IDLE, we=1, wa == ra[i] != 0: rd = wd, and busy_rd = 0 unless the same cycle also reserves that register (rsv_en=1, rsv_addr == wa).
  - Otherwise: rd = reg[ra[i]] and busy_rd = busy[ra[i]].
- Write, IDLE only: when we=1 and wa != 0, reg[wa] <= wd and busy[wa] <= 0 on the rising edge. Writes to register 0 are dropped.
- Reserve, IDLE only: when rsv_en=1 and rsv_addr != 0, busy[rsv_addr] <= 1.
- Write and reserve to the same address in the same cycle: the data is written and busy ends at 1 (reserve wins; a new producer is pending).
- Write and reserve to different addresses in the same cycle: both take effect.
- FSM has two states, IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1. Counter loads 1. The write and reserve presented in that same cycle are dropped.
  - In CLEAR, each cycle: reg[cnt] <= 0, busy[cnt] <= 0, cnt <= cnt+1.
  - CLEAR -> IDLE on the cycle that clears register NREG-1.
  - The sequence takes exactly NREG-1 cycles in CLEAR. clr_busy = (state == CLEAR) and is registered.
- In CLEAR:
  - we and rsv_en are ignored and bypass is disabled;
  - reads return the current stored contents, so already-cleared registers read 0;
  - clr_req is ignored.
- clr_req in the first IDLE cycle after CLEAR starts a new sequence.
- Asserting reset_n low mid-CLEAR aborts the sequence immediately and applies the full reset state.
- The counter is AW bits wide and never wraps: exit happens at NREG-1.
- X on ra while idle must not corrupt state. Stored state is only updated from we/wa/wd, rsv_en/rsv_addr and the clear engine.

Decomposition:
- Package regfile_pkg holds:
  - typedef enum logic {IDLE, CLEAR} rf_state_t;
  - default constants RF_XLEN=32, RF_NREG=32;
  - function is_zero_addr().
- Sub-module rf_scoreboard: NREG busy bits with the reserve/clear-on-write/clear-engine ports, plus NREAD lookups. It is instantiated once.
- The data array, bypass muxes and clear FSM stay in regfile_mp.

Test Plan:
- Reset then read: release reset_n; set ra0=5, ra1=31 -> rd0=0, rd1=0, busy_rd=2'b00, clr_busy=0.
- Write/read and x0: write we=1, wa=3, wd=32'hDEADBEEF; next cycle ra0=3 -> rd0=32'hDEADBEEF. Write wa=0, wd=32'h1234; read ra1=0 -> 0.
- Bypass (BYPASS=1) vs no bypass (BYPASS=0), reg 7 holding 32'h11:
  - BYPASS=1: same cycle we=1, wa=7, wd=32'hA5A5A5A5 with ra0=7 -> rd0=32'hA5A5A5A5 before the edge.
  - BYPASS=0: rd0=32'h11 before the edge and 32'hA5A5A5A5 after it.
- Scoreboard:
  - rsv_en with rsv_addr=9 -> next cycle busy_rd0=1 for ra0=9.
  - Write wa=9 -> busy clears.
  - Simultaneous rsv_en with rsv_addr=9 and we with wa=9 -> busy stays 1 and data is updated.
- Clear sequence:
  - Fill regs 1..31 with value = index and reserve reg 4.
  - Pulse clr_req -> clr_busy high for exactly 31 cycles.
  - A write we=1, wa=2, wd=32'hFF during CLEAR is dropped.
  - Afterwards all regs read 0 and busy_rd=0.
- Reset mid-clear: pulse clr_req and drop reset_n after 10 cycles -> clr_busy=0 immediately. All regs 0 after release, and a new write to wa=5 succeeds.
